fft_spectrum_src: RTL and testbench
===================================

Name: fft_spectrum_src

Overview:
- Transmit-side producer of the spectrum stream that the LCD spectrum display consumes as fft_data/fft_sop/fft_eop/fft_valid.
- Takes complex bins from the FFT core's streaming source and computes a 16-bit magnitude estimate.
- Forwards only the first N/2 bins of each frame, framed with sop/eop/valid. Optionally decimates frames so the display FIFO is not overrun.
- Sits between the FFT core and the LCD display in the clk_50m domain.

Parameters:
- N, 128, FFT points per input frame (power of 2, ≥4).
- IN_W, 16, signed width of in_real/in_imag.
- OUT_W, 16, unsigned width of out_data.
- DECIM, 4, emit one frame out of every DECIM valid input frames (1 = every frame).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid. No backpressure.
- in_sop  in  1  first bin of frame. Qualified by in_valid.
- in_eop  in  1  last bin of frame. Qualified by in_valid.
- in_real  in  IN_W  signed real part.
- in_imag  in  IN_W  signed imaginary part.
- out_data  out  OUT_W  magnitude estimate.
- out_sop  out  1  first output bin (bin 0).
- out_eop  out  1  last output bin (bin N/2-1).
- out_valid  out  1  output beat valid.
- err_frame  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: rst_n sampled low on a clk edge clears all outputs, pipeline, bin counter, frame counter and FSM (→IDLE). A reset mid-frame discards the frame. No partial tail is emitted after reset.
- Magnitude: |x| in IN_W+1 bits, so -32768 gives 32768. mag = max(|re|,|im|) + (min(|re|,|im|) >> 1), truncated. Saturate to 2^OUT_W-1 if the result exceeds OUT_W bits. With IN_W=OUT_W=16 the maximum is 49152, so saturation never occurs.
- Pipeline: 2 stages (abs, then max/min/add). out_* appears exactly 2 cycles after the accepted in_valid beat.
- FSM, state IDLE:
  - in_valid&in_sop → ACTIVE, bin=1.
  - If frame_cnt==0, the frame is marked emit and this beat goes out with out_sop.
  - Beats without sop are ignored silently.
- FSM, state ACTIVE (bin 1..N-1):
  - Each in_valid increments bin.
  - Bins < N/2 are emitted if the frame is marked emit. Bin N/2-1 carries out_eop. Bins ≥ N/2 are dropped.
  - in_eop at bin N-1: frame complete, → IDLE, frame_cnt = (frame_cnt+1) mod DECIM.
- Errors (all pulse err_frame 2 cycles after the offending beat):
  - in_sop during ACTIVE: restart the frame at bin 0 with this beat as the new sop. frame_cnt is not advanced.
  - in_eop before bin N-1: → IDLE, frame_cnt not advanced.
  - Bin N-1 without in_eop: → IDLE, frame_cnt not advanced.
- Truncated output on error: an emitted frame that errors before bin N/2-1 leaves its output frame without out_eop. The consumer resynchronises on the next out_sop. No padding is produced.
- Output qualification: out_sop/out_eop are asserted only when out_valid=1. out_valid stays low between beats when in_valid gaps occur; gaps propagate unchanged.
- Simultaneous sop and eop in IDLE with N>1: treated as an early-eop error. The beat is not emitted.

Optional Feature:
- Macro: FFT_SPECTRUM_PEAK_HOLD_EN.
- Defined:
  - Add an N/2-entry OUT_W peak register array indexed by bin.
  - Stage 2 outputs max(mag, peak[bin] − (peak[bin]>>4)) and writes it back, but only for emitted bins.
  - The array is cleared on reset. Latency is unchanged.
- Undefined: out_data = mag. No array.

Decomposition:
- Package fft_spectrum_pkg holds:
  - FSM state enum (IDLE, ACTIVE).
  - Function clog2 for bin/frame counter widths.
  - Constant HALF_N = N/2.
  - Magnitude function abs_max_min.
- Sub-module fft_mag_est: the 2-stage magnitude pipeline. Its in/out are valid, sop, eop and a bin tag. The top keeps the FSM, decimation and peak-hold.

Test Plan:
- Setup: N=128, DECIM=1. Inputs are one frame, bins 0..127 contiguous, re=bin, im=0.
  → 64 outputs, out_data=0..63, out_sop with 0, out_eop with 63, first output 2 cycles after input sop, no err.
- Magnitude corners: (re,im) = (-32768,-32768) → 49152; (3,-4) → 5; (0,0) → 0; (-1,0) → 1.
- Decimation: DECIM=4, 8 back-to-back frames → exactly frames 0 and 4 emitted, 128 outputs total.
- Framing errors:
  - New sop at bin 40 → err_frame pulse, first partial frame lacks out_eop, restarted frame emits 64 beats.
  - eop at bin 100 → err pulse, FSM returns to IDLE.
- rst_n low for 1 cycle at bin 20 of an emitted frame → all outputs 0 next cycle, nothing emitted until the next sop.
- FFT_SPECTRUM_PEAK_HOLD_EN:
  - Frame A: bin 5 = 1600, others 0. Frame B: all 0 → frame B bin 5 = 1500.
  - Frame C input bin 5 = 2000 → output 2000.

Source files
------------

// File: rtl/fft_spectrum_pkg.sv
// Shared types and helpers for the FFT spectrum source: FSM state, counter sizing and
// the alpha-max-plus-beta-min magnitude estimate.
package fft_spectrum_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int N_DEFAULT = 128;
    localparam int HALF_N    = N_DEFAULT / 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // max + min/2 on unsigned magnitudes; one extra bit so the sum never wraps
    function automatic logic [32:0] abs_max_min(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mx;
        logic [31:0] mn;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return {1'b0, mx} + {2'b00, mn[31:1]};
    endfunction

endpackage

// File: rtl/fft_spectrum_src_mag_est.sv
// fft_mag_est: two-stage magnitude pipeline (abs, then max/min/add with saturation).
// Framing flags and the bin tag travel alongside the data with the same latency.
module fft_mag_est
    import fft_spectrum_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int TAG_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic signed [IN_W-1:0]  in_real,
    input  logic signed [IN_W-1:0]  in_imag,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [TAG_W-1:0]        out_tag,
    output logic [OUT_W-1:0]        out_mag
);

    logic             s1_valid;
    logic             s1_sop;
    logic             s1_eop;
    logic [TAG_W-1:0] s1_tag;
    logic [IN_W:0]    s1_abs_re;
    logic [IN_W:0]    s1_abs_im;
    logic [32:0]      sum;
    logic [OUT_W-1:0] sat;

    // sign-extend first so the most negative input maps to +2^(IN_W-1)
    function automatic logic [IN_W:0] abs_ext(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] w;
        w = {x[IN_W-1], x};
        return w[IN_W] ? -w : w;
    endfunction

    always_comb begin
        sum = abs_max_min(32'(s1_abs_re), 32'(s1_abs_im));
        sat = (|sum[32:OUT_W]) ? '1 : sum[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_tag    <= '0;
            s1_abs_re <= '0;
            s1_abs_im <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_tag   <= '0;
            out_mag   <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_sop    <= in_sop;
            s1_eop    <= in_eop;
            s1_tag    <= in_tag;
            s1_abs_re <= abs_ext(in_real);
            s1_abs_im <= abs_ext(in_imag);
            out_valid <= s1_valid;
            out_sop   <= s1_sop;
            out_eop   <= s1_eop;
            out_tag   <= s1_tag;
            out_mag   <= sat;
        end
    end

endmodule

// File: rtl/fft_spectrum_src.sv
// FFT spectrum source: frames the first N/2 magnitude bins, decimates frames and flags
// framing errors. Optional peak-hold with decay is built when FFT_SPECTRUM_PEAK_HOLD_EN is defined.
//   state  | meaning
//   IDLE   | waiting for an in_sop beat
//   ACTIVE | inside a frame, bin_q is the index of the next beat
module fft_spectrum_src
    import fft_spectrum_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int DECIM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic signed [IN_W-1:0] in_real,
    input  logic signed [IN_W-1:0] in_imag,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_valid,
    output logic                   err_frame
);

    localparam int HALF  = N / 2;
    localparam int BIN_W = clog2(N);
    localparam int TAG_W = clog2(HALF);
    localparam int FC_W  = (DECIM > 1) ? clog2(DECIM) : 1;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             emit_q, emit_d;
    logic             beat_emit, beat_sop, beat_eop, beat_err;
    logic [TAG_W-1:0] beat_tag;
    logic             err_p1, err_p2;

    logic             mag_valid, mag_sop, mag_eop;
    logic [TAG_W-1:0] mag_tag;
    logic [OUT_W-1:0] mag;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        fcnt_d    = fcnt_q;
        emit_d    = emit_q;
        beat_emit = 1'b0;
        beat_sop  = 1'b0;
        beat_eop  = 1'b0;
        beat_err  = 1'b0;
        beat_tag  = '0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_sop) begin
                    if (in_eop) begin
                        beat_err = 1'b1;
                    end else begin
                        state_d   = ACTIVE;
                        bin_d     = BIN_W'(1);
                        emit_d    = (fcnt_q == '0);
                        beat_emit = (fcnt_q == '0);
                        beat_sop  = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        // restart in place; the decimation slot is unchanged
                        beat_err  = 1'b1;
                        bin_d     = BIN_W'(1);
                        emit_d    = (fcnt_q == '0);
                        beat_emit = (fcnt_q == '0);
                        beat_sop  = 1'b1;
                    end else begin
                        beat_tag  = bin_q[TAG_W-1:0];
                        beat_emit = emit_q && (bin_q < BIN_W'(HALF));
                        beat_eop  = (bin_q == BIN_W'(HALF - 1));
                        if (bin_q == BIN_W'(N - 1)) begin
                            state_d = IDLE;
                            if (in_eop) begin
                                fcnt_d = (fcnt_q == FC_W'(DECIM - 1)) ? '0 : fcnt_q + 1'b1;
                            end else begin
                                beat_err = 1'b1;
                            end
                        end else if (in_eop) begin
                            state_d  = IDLE;
                            beat_err = 1'b1;
                        end else begin
                            bin_d = bin_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            fcnt_q  <= '0;
            emit_q  <= 1'b0;
            err_p1  <= 1'b0;
            err_p2  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            fcnt_q  <= fcnt_d;
            emit_q  <= emit_d;
            err_p1  <= beat_err;
            err_p2  <= err_p1;
        end
    end

    fft_mag_est #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .TAG_W (TAG_W)
    ) u_mag_est (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (beat_emit),
        .in_sop    (beat_emit & beat_sop),
        .in_eop    (beat_emit & beat_eop),
        .in_tag    (beat_tag),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (mag_valid),
        .out_sop   (mag_sop),
        .out_eop   (mag_eop),
        .out_tag   (mag_tag),
        .out_mag   (mag)
    );

    assign out_valid = mag_valid;
    assign out_sop   = mag_sop;
    assign out_eop   = mag_eop & (mag_tag == TAG_W'(HALF - 1));
    assign err_frame = err_p2;

`ifdef FFT_SPECTRUM_PEAK_HOLD_EN
    logic [OUT_W-1:0] peak_q [HALF];
    logic [OUT_W-1:0] decayed;
    logic [OUT_W-1:0] held;

    // peak decays by 1/16 per emitted frame, so a stale peak fades out
    always_comb begin
        decayed = peak_q[mag_tag] - (peak_q[mag_tag] >> 4);
        held    = (mag > decayed) ? mag : decayed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HALF; i++) peak_q[i] <= '0;
        end else if (mag_valid) begin
            peak_q[mag_tag] <= held;
        end
    end

    assign out_data = held;
`else
    assign out_data = mag;
`endif

endmodule

// File: tb/tb_fft_spectrum_src.sv
// Scoreboard bench for fft_spectrum_src (N=128, DECIM=4): directed frames push expected
// beats and error pulses with their due cycle; a negedge monitor pops and compares.
module tb_fft_spectrum_src;

    localparam int N     = 128;
    localparam int HALF  = 64;
    localparam int DECIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sop, in_eop;
    logic [15:0] in_real, in_imag;
    logic [15:0] out_data;
    logic        out_sop, out_eop, out_valid, err_frame;

    fft_spectrum_src #(.N(N), .IN_W(16), .OUT_W(16), .DECIM(DECIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_valid (out_valid),
        .err_frame (err_frame)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        bit sop;
        bit eop;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   out_count = 0;
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", int'(out_data), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", int'(out_data), mon_e.data);
                check("out_sop", int'(out_sop), int'(mon_e.sop));
                check("out_eop", int'(out_eop), int'(mon_e.eop));
                check("out_latency", cyc, mon_e.at);
            end
        end else begin
            check("sop_eop_qualified", int'({out_sop, out_eop}), 0);
        end
        if (err_frame === 1'b1) begin
            if (err_q.size() == 0) check("unexpected_err", 1, 0);
            else check("err_cycle", cyc, err_q.pop_front());
        end
    end

    task automatic beat(input bit v, input bit s, input bit e, input int re, input int im,
                        input bit ex, input int ed, input bit es, input bit ee, input bit er);
        exp_t x;
        @(posedge clk);
        #1;
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_real  = re[15:0];
        in_imag  = im[15:0];
        if (ex) begin
            x.data = ed;
            x.sop  = es;
            x.eop  = ee;
            x.at   = cyc + 2;
            exp_q.push_back(x);
        end
        if (er) err_q.push_back(cyc + 2);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        repeat (4) idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // re = bin index, im = 0, so the expected magnitude is the bin index itself
    task automatic run_frame(input int nbins, input bit emit, input bit has_eop,
                             input bit err_first, input bit err_last, input bit gaps);
        for (int k = 0; k < nbins; k++) begin
            if (gaps && k[0]) idle();
            beat(1'b1, k == 0, has_eop && (k == nbins - 1), k, 0,
                 emit && (k < HALF), k, k == 0, k == HALF - 1,
                 (err_first && k == 0) || (err_last && k == nbins - 1));
        end
    endtask

`ifdef FFT_SPECTRUM_PEAK_HOLD_EN
    task automatic peak_frame(input bit emit, input int v5, input int e5);
        for (int k = 0; k < N; k++)
            beat(1'b1, k == 0, k == N - 1, (k == 5) ? v5 : 0, 0,
                 emit && (k < HALF), (k == 5) ? e5 : 0, k == 0, k == HALF - 1, 1'b0);
    endtask
`endif

    initial begin
        #800000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int cre [6] = '{-32768, 3, 0, -1, 100, -7};
    int cim [6] = '{-32768, -4, 0, 0, -300, 7};
    int cexp[6] = '{49152, 5, 0, 1, 350, 10};
    int base;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_real = '0; in_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_sop", int'(out_sop), 0);
        check("reset_eop", int'(out_eop), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_err", int'(err_frame), 0);
        rst_n = 1'b1;

        // eight back-to-back frames: only frames 0 and 4 are forwarded
        base = out_count;
        for (int f = 0; f < 8; f++) run_frame(N, (f % DECIM) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) idle();
        check("decim_out_count", out_count - base, 2 * HALF);

        // magnitude corners in the next emitted frame
        for (int k = 0; k < N; k++)
            beat(1'b1, k == 0, k == N - 1, (k < 6) ? cre[k] : 0, (k < 6) ? cim[k] : 0,
                 k < HALF, (k < 6) ? cexp[k] : 0, k == 0, k == HALF - 1, 1'b0);

        // sop at bin 40 restarts the frame; the partial frame has no eop
        do_reset();
        run_frame(40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(N, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // early eop at bin 100, stray beats ignored, slot not consumed (next frame emitted, with gaps)
        do_reset();
        run_frame(101, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) beat(1'b1, 1'b0, 1'b0, 7, 7, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_frame(N, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // missing eop at bin 127 does not advance the decimation counter (now 1)
        run_frame(N, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(N, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // sop together with eop in IDLE is an error and is not emitted
        do_reset();
        beat(1'b1, 1'b1, 1'b1, 55, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        run_frame(N, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset at bin 20: bins up to 18 already left the pipeline, nothing after
        do_reset();
        for (int k = 0; k < 20; k++)
            beat(1'b1, k == 0, 1'b0, k, 0, k <= 18, k, k == 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b1; in_sop = 1'b0; in_real = 16'd20;
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_sop", int'(out_sop), 0);
        check("midrst_data", int'(out_data), 0);
        check("midrst_err", int'(err_frame), 0);
        for (int k = 21; k < 41; k++) beat(1'b1, 1'b0, 1'b0, k, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_frame(N, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef FFT_SPECTRUM_PEAK_HOLD_EN
        do_reset();
        peak_frame(1'b1, 1600, 1600);
        for (int f = 0; f < 3; f++) peak_frame(1'b0, 0, 0);
        peak_frame(1'b1, 0, 1500);
        for (int f = 0; f < 3; f++) peak_frame(1'b0, 0, 0);
        peak_frame(1'b1, 2000, 2000);
`endif

        repeat (6) idle();
        check("exp_queue_drained", exp_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
